// File: rtl/sum_accumulator_pkg.sv
// Shared types and elaboration helpers for the sum accumulator.
package sum_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  // Ceiling log2 for sizing parameters at elaboration time.
  function automatic int clog2_f(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sum_accumulator_adder.sv
// Multibit ripple-carry adder; s[N] is the carry-out of the top bit.
module sum_accumulator_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   s
);

  logic carry;

  always_comb begin
    carry = 1'b0;
    s     = '0;
    for (int i = 0; i < N; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    s[N] = carry;
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates BATCH upstream sums (or a flushed partial batch) and emits
// the saturating total with its beat count over a valid/ready handshake.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int N     = 8,
  parameter int BATCH = 4,
  parameter int ACC_W = N + 1 + clog2_f(BATCH),
  parameter int CNT_W = clog2_f(BATCH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       in_sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  if (ACC_W < N + 1) begin : g_acc_w_check
    $error("sum_accumulator: ACC_W must be >= N+1");
  end
  if (BATCH < 1) begin : g_batch_check
    $error("sum_accumulator: BATCH must be >= 1");
  end

  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BATCH - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_upd;
  logic [CNT_W-1:0] cnt, cnt_upd;
  logic             sat, sat_upd;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             close;

  sum_accumulator_adder #(
    .N (ACC_W)
  ) u_adder (
    .a (acc),
    .b (ACC_W'(in_sum)),
    .s (sum)
  );

  // Post-beat values; a carry-out pins the total at full scale.
  always_comb begin
    in_ready  = (state == ACCUM);
    accept    = in_ready & in_valid;
    acc_upd   = acc;
    cnt_upd   = cnt;
    sat_upd   = sat;
    state_nxt = state;
    if (accept) begin
      acc_upd = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
      sat_upd = sat | sum[ACC_W];
      cnt_upd = cnt + 1'b1;
    end
    close = (state == ACCUM) &&
            ((accept && (cnt == CNT_LAST)) || (flush && (accept || (cnt != '0))));
    case (state)
      ACCUM:   if (close)     state_nxt = EMIT;
      EMIT:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (state == ACCUM) begin
      if (close) begin
        out_acc   <= acc_upd;
        out_count <= cnt_upd;
        out_sat   <= sat_upd;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        sat       <= 1'b0;
      end else begin
        acc <= acc_upd;
        cnt <= cnt_upd;
        sat <= sat_upd;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default build plus an ACC_W=9 build.
module tb_sum_accumulator;

  logic        clk;
  logic        rst_n;

  logic        in_valid, flush, out_ready;
  logic [8:0]  in_sum;
  logic        in_ready, out_valid, out_sat;
  logic [10:0] out_acc;
  logic [2:0]  out_count;

  logic        in_valid9, flush9, out_ready9;
  logic [8:0]  in_sum9;
  logic        in_ready9, out_valid9, out_sat9;
  logic [8:0]  out_acc9;
  logic [2:0]  out_count9;

  int vectors;
  int miscompares;

  sum_accumulator #(.N(8), .BATCH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  sum_accumulator #(.N(8), .BATCH(4), .ACC_W(9)) dut9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid9),
    .in_ready  (in_ready9),
    .in_sum    (in_sum9),
    .flush     (flush9),
    .out_valid (out_valid9),
    .out_ready (out_ready9),
    .out_acc   (out_acc9),
    .out_count (out_count9),
    .out_sat   (out_sat9)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [8:0] v, input logic f);
    in_valid = 1'b1;
    in_sum   = v;
    flush    = f;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic beat9(input logic [8:0] v, input logic f);
    in_valid9 = 1'b1;
    in_sum9   = v;
    flush9    = f;
    tick();
    in_valid9 = 1'b0;
    flush9    = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] acc,
                         input logic [31:0] count, input logic [31:0] sat);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_acc"},   32'(out_acc),   acc);
    chk({tag, "_count"}, 32'(out_count), count);
    chk({tag, "_sat"},   32'(out_sat),   sat);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0; flush  = 1'b0; out_ready  = 1'b1; in_sum  = '0;
    in_valid9   = 1'b0; flush9 = 1'b0; out_ready9 = 1'b1; in_sum9 = '0;

    // Reset values
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_acc",   32'(out_acc),   32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_sat",   32'(out_sat),   32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Full batch 10+20+30+40
    beat(9'd10, 1'b0);
    beat(9'd20, 1'b0);
    beat(9'd30, 1'b0);
    chk("mid_batch_out_valid", 32'(out_valid), 32'd0);
    beat(9'd40, 1'b0);
    chk_out("b1", 32'd100, 32'd4, 32'd0);
    tick();
    chk("b1_handshake_valid", 32'(out_valid), 32'd0);
    chk("b1_handshake_in_ready", 32'(in_ready), 32'd1);
    chk("b1_hold_acc", 32'(out_acc), 32'd100);

    // Largest inputs without overflow in the wide accumulator
    beat(9'd511, 1'b0);
    beat(9'd511, 1'b0);
    beat(9'd511, 1'b0);
    beat(9'd511, 1'b0);
    chk_out("b2", 32'd2044, 32'd4, 32'd0);
    tick();

    // Flush alongside the third beat
    beat(9'd3, 1'b0);
    beat(9'd4, 1'b0);
    beat(9'd5, 1'b1);
    chk_out("b3", 32'd12, 32'd3, 32'd0);
    tick();
    chk("b3_handshake_valid", 32'(out_valid), 32'd0);

    // Flush on an empty batch is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("empty_flush_valid", 32'(out_valid), 32'd0);
    tick();
    chk("empty_flush_valid2", 32'(out_valid), 32'd0);

    // Backpressure: stall the sink with in_valid held high
    out_ready = 1'b0;
    beat(9'd1, 1'b0);
    beat(9'd2, 1'b0);
    beat(9'd3, 1'b0);
    beat(9'd4, 1'b0);
    in_valid = 1'b1;
    in_sum   = 9'd99;
    flush    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("stall%0d", i), 32'd10, 32'd4, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    flush     = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    beat(9'd1, 1'b0);
    beat(9'd1, 1'b0);
    beat(9'd1, 1'b0);
    beat(9'd1, 1'b0);
    chk_out("post_stall", 32'd4, 32'd4, 32'd0);
    tick();

    // Asynchronous reset mid-batch discards partial data
    beat(9'd7, 1'b0);
    beat(9'd7, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_acc",   32'(out_acc),   32'd0);
    chk("async_rst_count", 32'(out_count), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    beat(9'd1, 1'b0);
    beat(9'd1, 1'b0);
    beat(9'd1, 1'b0);
    chk("after_rst_partial_valid", 32'(out_valid), 32'd0);
    beat(9'd1, 1'b0);
    chk_out("after_rst", 32'd4, 32'd4, 32'd0);
    tick();

    // Narrow accumulator: saturating partial batch, then a clean batch
    beat9(9'd300, 1'b0);
    beat9(9'd300, 1'b0);
    chk("acc9_pre_flush_valid", 32'(out_valid9), 32'd0);
    flush9 = 1'b1;
    tick();
    flush9 = 1'b0;
    chk("acc9_sat_valid", 32'(out_valid9), 32'd1);
    chk("acc9_sat_acc",   32'(out_acc9),   32'd511);
    chk("acc9_sat_count", 32'(out_count9), 32'd2);
    chk("acc9_sat_flag",  32'(out_sat9),   32'd1);
    tick();
    beat9(9'd5, 1'b0);
    beat9(9'd6, 1'b0);
    beat9(9'd7, 1'b0);
    beat9(9'd8, 1'b0);
    chk("acc9_b2_valid", 32'(out_valid9), 32'd1);
    chk("acc9_b2_acc",   32'(out_acc9),   32'd26);
    chk("acc9_b2_count", 32'(out_count9), 32'd4);
    chk("acc9_b2_sat",   32'(out_sat9),   32'd0);
    tick();
    chk("acc9_b2_handshake", 32'(out_valid9), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
